// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - next-PC sequencer between issue, branch comparator and fetch
// One request in flight at a time; outputs decode from state and registered PC only.
module pc_sequencer #(
   parameter logic [31:0] BOOT_ADDR = 32'h0000_0080,
   parameter int          CNT_W     = 16
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             boot_i,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [1:0]       req_kind_i,
   input  logic [31:0]      req_pc_i,
   input  logic [31:0]      req_off_i,
   input  logic             cmp_valid_i,
   output logic             cmp_ready_o,
   input  logic             cmp_result_i,
   output logic             pc_valid_o,
   input  logic             pc_ready_i,
   output logic [31:0]      pc_o,
   output logic             misalign_o,
   output logic             busy_o,
   output logic [CNT_W-1:0] taken_cnt_o
);

   typedef enum logic [1:0] {
      BOOT     = 2'd0,
      IDLE     = 2'd1,
      WAIT_CMP = 2'd2,
      EMIT     = 2'd3
   } state_t;

   localparam logic [1:0]       KIND_JUMP   = 2'b01;
   localparam logic [1:0]       KIND_BRANCH = 2'b10;
   localparam logic [31:0]      SEQ_STEP    = 32'd4;
   localparam logic [CNT_W-1:0] CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

   state_t           state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [31:0]      a_q, a_d;
   logic [31:0]      b_q, b_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= BOOT;
         pc_q    <= BOOT_ADDR;
         a_q     <= '0;
         b_q     <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         a_q     <= a_d;
         b_q     <= b_d;
         cnt_q   <= cnt_d;
      end
   end

   // boot_i overrides any handshake completing in the same cycle
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      a_d     = a_q;
      b_d     = b_q;
      cnt_d   = cnt_q;
      if (boot_i) begin
         state_d = BOOT;
         pc_d    = BOOT_ADDR;
         cnt_d   = '0;
      end else begin
         case (state_q)
            BOOT: begin
               pc_d    = BOOT_ADDR;
               state_d = EMIT;
            end
            IDLE: begin
               if (req_valid_i) begin
                  if (req_kind_i == KIND_JUMP) begin
                     pc_d    = req_pc_i + req_off_i;
                     state_d = EMIT;
                  end else if (req_kind_i == KIND_BRANCH) begin
                     a_d     = req_pc_i;
                     b_d     = req_off_i;
                     state_d = WAIT_CMP;
                  end else begin
                     pc_d    = req_pc_i + SEQ_STEP;
                     state_d = EMIT;
                  end
               end
            end
            WAIT_CMP: begin
               if (cmp_valid_i) begin
                  if (cmp_result_i) begin
                     pc_d = a_q + b_q;
                     if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_ONE;
                     end
                  end else begin
                     pc_d = a_q + SEQ_STEP;
                  end
                  state_d = EMIT;
               end
            end
            EMIT: begin
               if (pc_ready_i) begin
                  state_d = IDLE;
               end
            end
            default: state_d = BOOT;
         endcase
      end
   end

   assign req_ready_o = (state_q == IDLE);
   assign cmp_ready_o = (state_q == WAIT_CMP);
   assign pc_valid_o  = (state_q == EMIT);
   assign busy_o      = (state_q != IDLE);
   assign pc_o        = pc_q;
   assign misalign_o  = (state_q == EMIT) && (pc_q[1:0] != 2'b00);
   assign taken_cnt_o = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer
// Vector table plus hand sequences; emitted PCs are checked against a scoreboard queue.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        boot;
   logic        req_valid;
   logic [1:0]  req_kind;
   logic [31:0] req_pc;
   logic [31:0] req_off;
   logic        cmp_valid;
   logic        cmp_result;
   logic        pc_ready;

   logic        req_ready, cmp_ready, pc_valid, misalign, busy;
   logic [31:0] pc;
   logic [15:0] taken_cnt;

   logic        s_req_ready, s_cmp_ready, s_pc_valid, s_misalign, s_busy;
   logic [31:0] s_pc;
   logic [3:0]  s_taken_cnt;

   always #5 clk = ~clk;

   pc_sequencer dut (
      .clk_i(clk), .rst_ni(rst_n), .boot_i(boot),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_kind_i(req_kind),
      .req_pc_i(req_pc), .req_off_i(req_off),
      .cmp_valid_i(cmp_valid), .cmp_ready_o(cmp_ready), .cmp_result_i(cmp_result),
      .pc_valid_o(pc_valid), .pc_ready_i(pc_ready), .pc_o(pc),
      .misalign_o(misalign), .busy_o(busy), .taken_cnt_o(taken_cnt)
   );

   pc_sequencer #(.CNT_W(4)) dut_small (
      .clk_i(clk), .rst_ni(rst_n), .boot_i(boot),
      .req_valid_i(req_valid), .req_ready_o(s_req_ready), .req_kind_i(req_kind),
      .req_pc_i(req_pc), .req_off_i(req_off),
      .cmp_valid_i(cmp_valid), .cmp_ready_o(s_cmp_ready), .cmp_result_i(cmp_result),
      .pc_valid_o(s_pc_valid), .pc_ready_i(pc_ready), .pc_o(s_pc),
      .misalign_o(s_misalign), .busy_o(s_busy), .taken_cnt_o(s_taken_cnt)
   );

   int checks = 0;
   int failures = 0;
   int xfers = 0;
   int cnt_model = 0;
   logic [31:0] exp_q[$];

   typedef struct {
      logic [1:0]  kind;
      logic [31:0] a;
      logic [31:0] b;
      logic        res;
      int          delay;
      logic [31:0] exp_pc;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_cnt();
      int small_exp;
      small_exp = (cnt_model > 15) ? 15 : cnt_model;
      chk("taken_cnt", {16'b0, taken_cnt}, cnt_model);
      chk("taken_cnt_sat4", {28'b0, s_taken_cnt}, small_exp);
   endtask

   // transfer happens at the next rising edge when valid & ready and no boot
   always @(negedge clk) begin
      if (rst_n && !boot && pc_valid && pc_ready) begin
         logic [31:0] e;
         xfers++;
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL spurious_pc actual=0x%0h expected=none", pc);
         end else begin
            e = exp_q.pop_front();
            chk("pc_out", pc, e);
            chk("misalign", {31'b0, misalign}, {31'b0, |e[1:0]});
         end
      end
   end

   task automatic wait_ready();
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (req_ready) return;
      end
      chk("req_ready_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 50; i++) begin
         @(posedge clk);
         #1;
         if (exp_q.size() == 0) return;
      end
      chk("drain_timeout", exp_q.size(), 32'd0);
      exp_q.delete();
   endtask

   task automatic send(input vec_t v);
      wait_ready();
      req_valid = 1'b1;
      req_kind  = v.kind;
      req_pc    = v.a;
      req_off   = v.b;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      exp_q.push_back(v.exp_pc);
      if (v.kind == 2'b10) begin
         for (int d = 0; d < v.delay; d++) begin
            @(negedge clk);
            chk("cmp_ready_wait", {31'b0, cmp_ready}, 32'd1);
            chk("pc_valid_wait", {31'b0, pc_valid}, 32'd0);
         end
         @(negedge clk);
         cmp_valid  = 1'b1;
         cmp_result = v.res;
         @(posedge clk);
         #1;
         cmp_valid = 1'b0;
         if (v.res) cnt_model++;
         @(negedge clk);
         chk("cmp_to_emit", {31'b0, pc_valid}, 32'd1);
      end else begin
         @(negedge clk);
         chk("req_to_emit", {31'b0, pc_valid}, 32'd1);
      end
      wait_drain();
      chk_cnt();
   endtask

   vec_t vecs[8];

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{2'b01, 32'h0000_0100, 32'hFFFF_FFF0, 1'b0, 0, 32'h0000_00F0};
      vecs[1] = '{2'b00, 32'hFFFF_FFFC, 32'h1234_5678, 1'b0, 0, 32'h0000_0000};
      vecs[2] = '{2'b10, 32'h0000_0200, 32'h0000_0040, 1'b1, 3, 32'h0000_0240};
      vecs[3] = '{2'b10, 32'h0000_0200, 32'h0000_0040, 1'b0, 3, 32'h0000_0204};
      vecs[4] = '{2'b11, 32'h0000_1000, 32'h0000_0055, 1'b0, 0, 32'h0000_1004};
      vecs[5] = '{2'b01, 32'h0000_0100, 32'h0000_0002, 1'b0, 0, 32'h0000_0102};
      vecs[6] = '{2'b10, 32'hFFFF_FFF0, 32'h0000_0020, 1'b1, 0, 32'h0000_0010};
      vecs[7] = '{2'b10, 32'h0000_0010, 32'h0000_0007, 1'b1, 1, 32'h0000_0017};

      rst_n = 1'b0; boot = 1'b0; req_valid = 1'b0; req_kind = 2'b00;
      req_pc = '0; req_off = '0; cmp_valid = 1'b0; cmp_result = 1'b0; pc_ready = 1'b1;

      repeat (2) @(negedge clk);
      chk("rst_pc", pc, 32'h80);
      chk("rst_pc_valid", {31'b0, pc_valid}, 32'd0);
      chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
      chk("rst_cmp_ready", {31'b0, cmp_ready}, 32'd0);
      chk("rst_misalign", {31'b0, misalign}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd1);
      chk_cnt();

      exp_q.push_back(32'h80);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("boot_emit_valid", {31'b0, pc_valid}, 32'd0);
      @(negedge clk);
      chk("boot_emit_valid_e1", {31'b0, pc_valid}, 32'd1);
      chk("boot_emit_pc", pc, 32'h80);
      @(negedge clk);
      chk("idle_req_ready", {31'b0, req_ready}, 32'd1);
      chk("idle_busy", {31'b0, busy}, 32'd0);

      for (int i = 0; i < 8; i++) send(vecs[i]);

      // IF backpressure: hold EMIT while issue and comparator poke at it
      wait_ready();
      req_valid = 1'b1; req_kind = 2'b01; req_pc = 32'h0000_4000; req_off = 32'h0000_0010;
      pc_ready = 1'b0;
      @(posedge clk);
      #1;
      exp_q.push_back(32'h0000_4010);
      req_kind = 2'b00; req_pc = 32'h0000_9000; cmp_valid = 1'b1; cmp_result = 1'b1;
      begin
         int x0;
         x0 = xfers;
         for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_pc_valid", {31'b0, pc_valid}, 32'd1);
            chk("bp_pc_hold", pc, 32'h0000_4010);
            chk("bp_req_ready", {31'b0, req_ready}, 32'd0);
         end
         @(posedge clk);
         #1;
         req_valid = 1'b0; cmp_valid = 1'b0; pc_ready = 1'b1;
         wait_drain();
         @(negedge clk);
         chk("bp_one_xfer", xfers - x0, 32'd1);
         chk("bp_back_idle", {31'b0, req_ready}, 32'd1);
         chk("bp_no_extra_pc", {31'b0, pc_valid}, 32'd0);
      end
      chk_cnt();

      // bring the counter to 7 before the boot collision
      while (cnt_model < 7) send('{2'b10, 32'h0000_0300, 32'h0000_0020, 1'b1, 0, 32'h0000_0320});
      chk("cnt_at_7", {16'b0, taken_cnt}, 32'd7);

      // boot collides with a comparator handshake and is held two cycles
      wait_ready();
      req_valid = 1'b1; req_kind = 2'b10; req_pc = 32'h0000_0500; req_off = 32'h0000_0100;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("bc_cmp_ready", {31'b0, cmp_ready}, 32'd1);
      cmp_valid = 1'b1; cmp_result = 1'b1; boot = 1'b1;
      @(posedge clk);
      #1 cmp_valid = 1'b0;
      cnt_model = 0;
      @(negedge clk);
      chk("bc_boot_pc", pc, 32'h80);
      chk("bc_boot_valid", {31'b0, pc_valid}, 32'd0);
      chk("bc_boot_busy", {31'b0, busy}, 32'd1);
      chk("bc_boot_cmp_ready", {31'b0, cmp_ready}, 32'd0);
      chk_cnt();
      @(posedge clk);
      #1 boot = 1'b0;
      exp_q.push_back(32'h80);
      @(negedge clk);
      chk("bc_hold_valid", {31'b0, pc_valid}, 32'd0);
      chk("bc_hold_req_ready", {31'b0, req_ready}, 32'd0);
      @(negedge clk);
      chk("bc_emit_valid", {31'b0, pc_valid}, 32'd1);
      wait_drain();
      chk_cnt();

      // saturation of the narrow counter with 17 taken branches
      for (int i = 0; i < 17; i++) begin
         vec_t v;
         logic [31:0] a;
         a = 32'h0000_1000 + 32'(i) * 32'h10;
         v = '{2'b10, a, 32'h0000_0008, 1'b1, int'($urandom_range(0, 2)), a + 32'h8};
         send(v);
      end
      chk("sat_cnt4", {28'b0, s_taken_cnt}, 32'hF);
      send('{2'b01, 32'h0000_0100, 32'h0000_0002, 1'b0, 0, 32'h0000_0102});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
